register_file_16: RTL and testbench

Sixteen-entry architectural register file feeding the operand-select multiplexers of the single-cycle datapath. Holds R0–R14 in flip-flops, presents R15 as the externally supplied PC+8 value, and provides two operand read ports plus one debug read port. Writes come from the write-back stage; a dedicated link port updates R14 for branch-with-link.

---
 rtl/register_file_16_pkg.sv | 7 +
 rtl/register_file_16_if.sv | 33 +++
 rtl/register_file_16_mux.sv | 46 ++++
 rtl/register_file_16.sv | 63 ++++++
 tb/tb_register_file_16.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/register_file_16_pkg.sv
// Shared constants for the sixteen-entry register file.
package register_file_16_pkg;
  localparam int       REG_COUNT = 16;
  localparam int       DEF_WIDTH = 32;
  localparam bit [3:0] LR_INDEX  = 4'd14;
  localparam bit [3:0] PC_INDEX  = 4'd15;
endpackage

// File: rtl/register_file_16_if.sv
// Write/link/read bundle between datapath and register file.
interface register_file_16_if
  import register_file_16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             write_enable;
  logic [3:0]       dest_select;
  logic [WIDTH-1:0] write_data;
  logic             link_enable;
  logic [WIDTH-1:0] link_data;
  logic [WIDTH-1:0] r15_value;
  logic [3:0]       src1_select;
  logic [3:0]       src2_select;
  logic [3:0]       debug_select;
  logic [WIDTH-1:0] read_data_1;
  logic [WIDTH-1:0] read_data_2;
  logic [WIDTH-1:0] debug_data;

  modport master (
    output write_enable, dest_select, write_data,
    output link_enable, link_data, r15_value,
    output src1_select, src2_select, debug_select,
    input  read_data_1, read_data_2, debug_data
  );

  modport slave (
    input  write_enable, dest_select, write_data,
    input  link_enable, link_data, r15_value,
    input  src1_select, src2_select, debug_select,
    output read_data_1, read_data_2, debug_data
  );
endinterface

// File: rtl/register_file_16_mux.sv
// Plain 16:1 operand multiplexer used by every read port.
module Mux_16to1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] input_0,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic [WIDTH-1:0] input_3,
  input  logic [WIDTH-1:0] input_4,
  input  logic [WIDTH-1:0] input_5,
  input  logic [WIDTH-1:0] input_6,
  input  logic [WIDTH-1:0] input_7,
  input  logic [WIDTH-1:0] input_8,
  input  logic [WIDTH-1:0] input_9,
  input  logic [WIDTH-1:0] input_10,
  input  logic [WIDTH-1:0] input_11,
  input  logic [WIDTH-1:0] input_12,
  input  logic [WIDTH-1:0] input_13,
  input  logic [WIDTH-1:0] input_14,
  input  logic [WIDTH-1:0] input_15,
  input  logic [3:0]       select,
  output logic [WIDTH-1:0] output_y
);
  always_comb begin
    output_y = input_0;
    case (select)
      4'd0:  output_y = input_0;
      4'd1:  output_y = input_1;
      4'd2:  output_y = input_2;
      4'd3:  output_y = input_3;
      4'd4:  output_y = input_4;
      4'd5:  output_y = input_5;
      4'd6:  output_y = input_6;
      4'd7:  output_y = input_7;
      4'd8:  output_y = input_8;
      4'd9:  output_y = input_9;
      4'd10: output_y = input_10;
      4'd11: output_y = input_11;
      4'd12: output_y = input_12;
      4'd13: output_y = input_13;
      4'd14: output_y = input_14;
      4'd15: output_y = input_15;
      default: output_y = input_0;
    endcase
  end
endmodule

// File: rtl/register_file_16.sv
// R0-R14 storage with write-back and link ports; R15 reads the
// fetch-supplied PC+8. Three combinational read ports, no bypass.
module register_file_16
  import register_file_16_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  register_file_16_if.slave bus
);
  localparam int NREG = REG_COUNT - 1;

  logic [WIDTH-1:0] r_regs [NREG];
  logic [3:0]       w_sel  [3];
  logic [WIDTH-1:0] w_rd   [3];

  // Write port is tested first so it beats the link port on R14.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (bus.write_enable && bus.dest_select == 4'(i))
          r_regs[i] <= bus.write_data;
        else if (4'(i) == LR_INDEX && bus.link_enable)
          r_regs[i] <= bus.link_data;
      end
    end
  end

  assign w_sel[0] = bus.src1_select;
  assign w_sel[1] = bus.src2_select;
  assign w_sel[2] = bus.debug_select;

  for (genvar p = 0; p < 3; p++) begin : g_rd
    Mux_16to1 #(.WIDTH(WIDTH)) u_mux (
      .input_0  (r_regs[0]),
      .input_1  (r_regs[1]),
      .input_2  (r_regs[2]),
      .input_3  (r_regs[3]),
      .input_4  (r_regs[4]),
      .input_5  (r_regs[5]),
      .input_6  (r_regs[6]),
      .input_7  (r_regs[7]),
      .input_8  (r_regs[8]),
      .input_9  (r_regs[9]),
      .input_10 (r_regs[10]),
      .input_11 (r_regs[11]),
      .input_12 (r_regs[12]),
      .input_13 (r_regs[13]),
      .input_14 (r_regs[14]),
      .input_15 (bus.r15_value),
      .select   (w_sel[p]),
      .output_y (w_rd[p])
    );
  end

  assign bus.read_data_1 = w_rd[0];
  assign bus.read_data_2 = w_rd[1];
  assign bus.debug_data  = w_rd[2];
endmodule

// File: tb/tb_register_file_16.sv
// Directed plus randomized bench for register_file_16 against an array model.
module tb_register_file_16;
  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] model [15];

  register_file_16_if #(.WIDTH(32)) bus ();

  register_file_16 #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] expect_rd(input logic [3:0] idx);
    return (idx == 4'd15) ? bus.r15_value : model[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Edge with model update from the values presented to the DUT.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      if (bus.link_enable) model[14] = bus.link_data;
      if (bus.write_enable && bus.dest_select != 4'd15)
        model[bus.dest_select] = bus.write_data;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    bus.write_enable = 0;
    bus.link_enable  = 0;
    for (int i = 0; i < 16; i++) begin
      bus.src1_select  = 4'(i);
      bus.src2_select  = 4'((i + 5) % 16);
      bus.debug_select = 4'((i + 11) % 16);
      #1;
      check({tag, "_p1"}, bus.read_data_1, expect_rd(bus.src1_select));
      check({tag, "_p2"}, bus.read_data_2, expect_rd(bus.src2_select));
      check({tag, "_dbg"}, bus.debug_data, expect_rd(bus.debug_select));
    end
  endtask

  initial begin
    logic [31:0] v;
    reset = 1;
    bus.write_enable = 0;
    bus.dest_select  = 0;
    bus.write_data   = 0;
    bus.link_enable  = 0;
    bus.link_data    = 0;
    bus.r15_value    = 32'h0000_0100;
    bus.src1_select  = 0;
    bus.src2_select  = 0;
    bus.debug_select = 0;
    for (int i = 0; i < 15; i++) model[i] = '0;
    tick();
    tick();
    reset = 0;
    check_all("reset");

    // Asynchronous clear between edges, pending write lost.
    bus.dest_select  = 4'd3;
    bus.write_data   = 32'hDEAD_BEEF;
    bus.write_enable = 1;
    tick();
    bus.write_enable = 0;
    bus.src1_select  = 4'd3;
    #1;
    check("r3_written", bus.read_data_1, 32'hDEAD_BEEF);
    bus.dest_select  = 4'd5;
    bus.write_data   = 32'h5555_5555;
    bus.write_enable = 1;
    reset = 1;
    #1;
    check("async_clear", bus.read_data_1, 32'h0);
    for (int i = 0; i < 15; i++) model[i] = '0;
    tick();
    reset = 0;
    bus.write_enable = 0;
    check_all("post_reset");

    // Write every register, old value visible until the edge.
    for (int i = 0; i < 15; i++) begin
      v = $urandom;
      bus.dest_select  = 4'(i);
      bus.write_data   = v;
      bus.write_enable = 1;
      bus.src2_select  = 4'(i);
      #1;
      check("pre_write", bus.read_data_2, model[i]);
      tick();
      bus.src1_select  = 4'(i);
      bus.debug_select = 4'(i);
      #1;
      check("post_write_p1", bus.read_data_1, v);
      check("post_write_p2", bus.read_data_2, v);
      check("post_write_dbg", bus.debug_data, v);
    end
    check_all("all_regs");

    // Writes to index 15 are dropped; reads return r15_value.
    bus.r15_value    = 32'h0000_0108;
    bus.dest_select  = 4'd15;
    bus.write_data   = 32'hFFFF_FFFF;
    bus.write_enable = 1;
    tick();
    check_all("r15");

    // Write port beats link port on R14.
    bus.dest_select  = 4'd14;
    bus.write_data   = 32'hAAAA_0000;
    bus.write_enable = 1;
    bus.link_data    = 32'h0000_0040;
    bus.link_enable  = 1;
    tick();
    bus.src1_select  = 4'd14;
    #1;
    check("link_collision", bus.read_data_1, 32'hAAAA_0000);

    // Write and link commit on the same edge.
    bus.dest_select  = 4'd2;
    bus.write_data   = 32'h11;
    bus.write_enable = 1;
    bus.link_data    = 32'h44;
    bus.link_enable  = 1;
    tick();
    bus.write_enable = 0;
    bus.link_enable  = 0;
    bus.src1_select  = 4'd2;
    bus.src2_select  = 4'd14;
    #1;
    check("dual_r2", bus.read_data_1, 32'h11);
    check("dual_r14", bus.read_data_2, 32'h44);
    check_all("dual");

    // Hold with toggling data.
    for (int c = 0; c < 10; c++) begin
      bus.write_data = $urandom;
      bus.link_data  = $urandom;
      bus.dest_select = 4'($urandom_range(0, 15));
      tick();
    end
    check_all("hold");

    // Random traffic.
    for (int c = 0; c < 150; c++) begin
      bus.write_enable = 1'($urandom);
      bus.dest_select  = 4'($urandom);
      bus.write_data   = $urandom;
      bus.link_enable  = ($urandom_range(0, 3) == 0);
      bus.link_data    = $urandom;
      bus.r15_value    = $urandom;
      tick();
      bus.src1_select  = 4'($urandom);
      bus.src2_select  = 4'($urandom);
      bus.debug_select = 4'($urandom);
      #1;
      check("rand_p1", bus.read_data_1, expect_rd(bus.src1_select));
      check("rand_p2", bus.read_data_2, expect_rd(bus.src2_select));
      check("rand_dbg", bus.debug_data, expect_rd(bus.debug_select));
    end
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
